// File: rtl/aw_chan_buffer.sv
// -----------------------------------------------------------------------------
// aw_chan_buffer
//
// Buffered AXI write-address (AW) channel stage. AW beats accepted on the
// slave side (inp_*) are stored in a DEPTH-entry FIFO and presented strictly
// in order on the master side (oup_*). The inp/oup valid/ready pairs are the
// handshake taps a downstream performance monitor observes, so they follow
// plain AXI rules: no push-through when full, payload stable while valid.
//
// Local statistics:
//   usage_o     - entries currently held
//   hwm_o       - highest usage since reset or the last stat_clr_i
//   stall_cnt_o - saturating count of cycles with oup valid high, ready low
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   stat_clr_i            synchronous clear of hwm_o / stall_cnt_o
//   inp_aw_*              slave-side AW channel (valid/addr/len/size/id/ready)
//   oup_aw_*              master-side AW channel (valid/addr/len/size/id/ready)
//   usage_o, hwm_o        occupancy and high-water mark
//   stall_cnt_o           back-pressure stall counter
// -----------------------------------------------------------------------------
module aw_chan_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stat_clr_i,

  input  logic                    inp_aw_valid_i,
  input  logic [ADDR_WIDTH-1:0]   inp_aw_addr_i,
  input  logic [7:0]              inp_aw_len_i,
  input  logic [2:0]              inp_aw_size_i,
  input  logic [ID_WIDTH-1:0]     inp_aw_id_i,
  output logic                    inp_aw_ready_o,

  output logic                    oup_aw_valid_o,
  output logic [ADDR_WIDTH-1:0]   oup_aw_addr_o,
  output logic [7:0]              oup_aw_len_o,
  output logic [2:0]              oup_aw_size_o,
  output logic [ID_WIDTH-1:0]     oup_aw_id_o,
  input  logic                    oup_aw_ready_i,

  output logic [$clog2(DEPTH):0]  usage_o,
  output logic [$clog2(DEPTH):0]  hwm_o,
  output logic [CNT_WIDTH-1:0]    stall_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int USAGE_W = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + 8 + 3 + ID_WIDTH;

  localparam logic [USAGE_W-1:0] FULL_LVL = USAGE_W'(DEPTH);

  // Storage and state
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [USAGE_W-1:0]   r_usage;
  logic [USAGE_W-1:0]   r_hwm;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Combinational helpers
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_stall;
  logic [USAGE_W-1:0]   w_usage_next;
  logic [ENTRY_W-1:0]   w_wr_entry;
  logic [ENTRY_W-1:0]   w_head;

  // Ready depends only on our own occupancy, never on oup_aw_ready_i, so a
  // full buffer stays unready for the whole cycle even if it pops.
  assign w_full   = (r_usage == FULL_LVL);
  assign w_empty  = (r_usage == '0);
  assign w_push   = inp_aw_valid_i & ~w_full;
  assign w_pop    = ~w_empty & oup_aw_ready_i;
  assign w_stall  = ~w_empty & ~oup_aw_ready_i;

  assign w_usage_next = r_usage + USAGE_W'(w_push) - USAGE_W'(w_pop);

  assign w_wr_entry = {inp_aw_addr_i, inp_aw_len_i, inp_aw_size_i, inp_aw_id_i};
  assign w_head     = r_mem[r_rd_ptr];

  assign inp_aw_ready_o = ~w_full;
  assign oup_aw_valid_o = ~w_empty;
  assign {oup_aw_addr_o, oup_aw_len_o, oup_aw_size_o, oup_aw_id_o} = w_head;

  assign usage_o     = r_usage;
  assign hwm_o       = r_hwm;
  assign stall_cnt_o = r_stall_cnt;

  // NOTE: the storage array is reset as well, so the payload outputs read 0
  // after reset instead of exposing stale beats; it costs a reset on every
  // storage flop, which is acceptable at these small depths.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      // NOTE: non-blocking assignments everywhere in clocked blocks, so every
      // read in this cycle sees the pre-edge state regardless of block order.
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); usage disambiguates
  // full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_usage <= w_usage_next;
    end
  end

  // High-water mark tracks usage_next so it agrees with usage_o next cycle;
  // a clear restarts it from the current occupancy rather than from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hwm <= '0;
    end else if (stat_clr_i || (w_usage_next > r_hwm)) begin
      r_hwm <= w_usage_next;
    end
  end

  // Saturating stall counter; clear has priority over a concurrent stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (stat_clr_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/aw_chan_buffer.md
# aw_chan_buffer

Buffered AXI write-address (AW) channel stage that sits on the monitored bus segment directly upstream of the performance monitor. It accepts AW beats on its slave side (inp), stores them in a DEPTH-entry FIFO, and presents them in order on its master side (oup). Its inp and oup valid/ready pairs are the exact handshake taps the performance monitor observes. It also exposes occupancy, a high-water mark, and a saturating back-pressure stall counter for local statistics.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- ADDR_WIDTH, 64, AW address width
- ID_WIDTH, 4, AW ID width
- CNT_WIDTH, 32, stall counter width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- stat_clr_i  in  1  synchronous clear of hwm_o and stall_cnt_o
- inp_aw_valid_i  in  1  slave-side AW valid
- inp_aw_addr_i  in  ADDR_WIDTH  AW address
- inp_aw_len_i  in  8  AW burst length (axi_pkg::len_t)
- inp_aw_size_i  in  3  AW beat size (axi_pkg::size_t)
- inp_aw_id_i  in  ID_WIDTH  AW ID
- inp_aw_ready_o  out  1  slave-side AW ready
- oup_aw_valid_o  out  1  master-side AW valid
- oup_aw_addr_o / oup_aw_len_o / oup_aw_size_o / oup_aw_id_o  out  matching widths  head-of-FIFO payload
- oup_aw_ready_i  in  1  master-side AW ready
- usage_o  out  $clog2(DEPTH)+1  current entries
- hwm_o  out  $clog2(DEPTH)+1  max usage since reset/clear
- stall_cnt_o  out  CNT_WIDTH  cycles with oup_aw_valid_o=1 and oup_aw_ready_i=0

## Operation
- push = inp_aw_valid_i & inp_aw_ready_o; pop = oup_aw_valid_o & oup_aw_ready_i.
- inp_aw_ready_o = (usage != DEPTH); independent of oup_aw_ready_i (no push-through when full).
- oup_aw_valid_o = (usage != 0); payload outputs driven from the read-pointer entry.
- Write and read pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH; usage is a separate counter.
- usage_next = usage + push − pop; push and pop in the same cycle leave usage unchanged and advance both pointers.
- Strict in-order delivery; no reordering by ID; payload never modified.
- hwm: if stat_clr_i then hwm ← usage_next; else hwm ← max(hwm, usage_next).
- stall_cnt: if stat_clr_i then 0; else +1 when oup_aw_valid_o & !oup_aw_ready_i; saturates at 2^CNT_WIDTH−1 (never wraps).
- Reset: pointers, usage_o, hwm_o, stall_cnt_o = 0; inp_aw_ready_o = 1; oup_aw_valid_o = 0; payload outputs = 0 (storage array cleared). Reset mid-burst discards all stored beats; no beat emitted afterwards.

## Timing
- Latency: beat pushed in cycle N is visible on oup at cycle N+1 if FIFO empty; otherwise behind earlier entries.
- Throughput: one push and one pop per cycle sustained when 0 < usage < DEPTH.
- Full: inp_aw_ready_o low in the cycle usage == DEPTH, even if a pop occurs that cycle; ready returns the cycle after the pop.
- Empty: oup_aw_valid_o low; oup_aw_ready_i ignored, no pointer change.
- AXI stability: once oup_aw_valid_o is high, it and the payload stay constant until pop.
- usage_o, hwm_o, stall_cnt_o are registered; they reflect events of the previous cycle.
- Simultaneous stat_clr_i and stall condition: clear wins (stall_cnt_o = 0 next cycle).

## Test plan
- Reset, then single push addr=0x1000,len=3,size=3,id=2 with oup_aw_ready_i=1 -> oup_aw_valid_o high exactly one cycle later with identical payload, usage_o 1 then 0, hwm_o=1.
- oup_aw_ready_i=0, push 5 beats (DEPTH=4) -> 4 accepted, inp_aw_ready_o low from 4th acceptance, usage_o=4, hwm_o=4, 5th beat held; stall_cnt_o counts each blocked cycle.
- Full FIFO, raise oup_aw_ready_i one cycle -> one pop, inp_aw_ready_o high next cycle, held beat accepted; order of 5 IDs 0..4 preserved at output.
- Continuous push+pop for 20 cycles with usage=2 -> usage_o stays 2, pointers wrap 5 times, all 20 IDs in order, no stalls.
- Force stall_cnt to all-ones (CNT_WIDTH=4, 20 stalled cycles) -> stall_cnt_o stays 15; assert stat_clr_i -> 0 next cycle, hwm_o = current usage.
- Assert rst_i asynchronously with usage=3 mid-cycle -> outputs reset immediately, oup_aw_valid_o=0, no stale beat after release.
